mem_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port data memory.
- Port 0 is the CPU load/store path. Port 1 is the debug/program-loader path.
- Serialises accesses, drives the memory address/write-enable/write-data, and waits out the memory read latency.
- Returns read data to the winning requester with a one-cycle response pulse. Sits between the CPU top level and DATA_MEMORY.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Serialises CPU (port 0) and debug-loader (port 1) accesses and waits out the read latency.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int READ_LAT   = 0,
  parameter int RR_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_we_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_we_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy
);

  generate
    if (READ_LAT < 0 || READ_LAT > 3) begin : g_bad_read_lat
      $error("mem_arbiter: READ_LAT must be in 0..3");
    end
  endgenerate

  localparam logic [1:0] LP_CNT_INIT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  r_we;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_cnt;
  logic                  w_pick_1;
  logic                  w_grant_0;
  logic                  w_grant_1;
  logic                  w_accept;
  logic                  w_capture;

  // Port 1 wins alone, or under contention when round-robin says port 0 went last.
  assign w_pick_1  = (RR_EN != 0) ? (req_valid_1 && (!req_valid_0 || !r_last_grant))
                                  : (req_valid_1 && !req_valid_0);
  assign w_grant_1 = (r_state == S_IDLE) && w_pick_1;
  assign w_grant_0 = (r_state == S_IDLE) && req_valid_0 && !w_pick_1;
  assign w_accept  = w_grant_0 || w_grant_1;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_we) begin
          w_state_nxt = S_RESP;
        end else if (READ_LAT == 0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= 2'd0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant_1;
        r_last_grant <= w_grant_1;
        r_we         <= w_grant_1 ? req_we_1    : req_we_0;
        r_addr       <= w_grant_1 ? req_addr_1  : req_addr_0;
        r_wdata      <= w_grant_1 ? req_wdata_1 : req_wdata_0;
      end
      if (r_state == S_ACCESS && !r_we) begin
        r_cnt <= LP_CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      // Stores report zero data, so clear the capture register as they pass ACCESS.
      if (w_capture) begin
        r_rdata <= mem_rd;
      end else if (r_state == S_ACCESS && r_we) begin
        r_rdata <= '0;
      end
    end
  end

  assign req_ready_0 = w_grant_0;
  assign req_ready_1 = w_grant_1;
  assign rsp_valid_0 = (r_state == S_RESP) && !r_owner;
  assign rsp_valid_1 = (r_state == S_RESP) && r_owner;
  assign rsp_rdata   = r_rdata;
  assign mem_a       = r_addr;
  assign mem_wd      = r_wdata;
  assign mem_we      = (r_state == S_ACCESS) && r_we;
  assign busy        = (r_state != S_IDLE);

endmodule
